// File: rtl/operand_pingpong_buffer_pkg.sv
// rtl/operand_pingpong_buffer_pkg.sv - shared sizing helpers and FSM state type
package operand_pingpong_buffer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int calc_max_dim(input int bus_width, input int data_width);
    return bus_width / data_width;
  endfunction

  function automatic int calc_addr_w(input int max_dim);
    return $clog2(max_dim);
  endfunction

  // One extra bit so a full-length count never aliases to zero.
  function automatic int calc_cnt_w(input int max_dim);
    return $clog2(max_dim) + 1;
  endfunction

endpackage

// File: rtl/operand_pingpong_buffer_if.sv
// rtl/operand_pingpong_buffer_if.sv - write port, control and row stream bundle
interface operand_pingpong_buffer_if
  import operand_pingpong_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64
);
  localparam int MAX_DIM = calc_max_dim(BUS_WIDTH, DATA_WIDTH);
  localparam int AW      = calc_addr_w(MAX_DIM);
  localparam int CW      = calc_cnt_w(MAX_DIM);

  logic                 write_enable_i;
  logic [AW-1:0]        address_i;
  logic [MAX_DIM-1:0]   strobe_i;
  logic [BUS_WIDTH-1:0] data_i;
  logic                 swap_i;
  logic                 start_send_i;
  logic [CW-1:0]        dim_i;
  logic                 ready_i;
  logic [BUS_WIDTH-1:0] data_o;
  logic                 valid_o;
  logic                 last_o;
  logic                 done_o;
  logic                 busy_o;
  logic                 rd_bank_o;

  modport master (
    output write_enable_i, address_i, strobe_i, data_i, swap_i, start_send_i, dim_i, ready_i,
    input  data_o, valid_o, last_o, done_o, busy_o, rd_bank_o
  );

  modport slave (
    input  write_enable_i, address_i, strobe_i, data_i, swap_i, start_send_i, dim_i, ready_i,
    output data_o, valid_o, last_o, done_o, busy_o, rd_bank_o
  );

endinterface

// File: rtl/operand_pingpong_buffer_bank.sv
// rtl/operand_pingpong_buffer_bank.sv - one operand bank: strobed row writes, async read, sync clear
module operand_pingpong_buffer_bank
  import operand_pingpong_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  localparam int MAX_DIM   = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
  localparam int AW        = calc_addr_w(MAX_DIM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [MAX_DIM-1:0]   strobe,
  input  logic [BUS_WIDTH-1:0] wdata,
  input  logic                 clr,
  input  logic [AW-1:0]        raddr,
  output logic [BUS_WIDTH-1:0] rdata
);
  logic [BUS_WIDTH-1:0] mem [MAX_DIM];

  // A strobed write wins over a simultaneous clear, element by element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MAX_DIM; r++) mem[r] <= '0;
    end else begin
      for (int r = 0; r < MAX_DIM; r++) begin
        for (int b = 0; b < MAX_DIM; b++) begin
          if (we && (waddr == AW'(r)) && strobe[b])
            mem[r][b*DATA_WIDTH +: DATA_WIDTH] <= wdata[b*DATA_WIDTH +: DATA_WIDTH];
          else if (clr)
            mem[r][b*DATA_WIDTH +: DATA_WIDTH] <= '0;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int r = 0; r < MAX_DIM; r++)
      if (raddr == AW'(r)) rdata = mem[r];
  end

endmodule

// File: rtl/operand_pingpong_buffer.sv
// rtl/operand_pingpong_buffer.sv - ping-pong operand store with row streaming and deferred bank swap
module operand_pingpong_buffer
  import operand_pingpong_buffer_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int BUS_WIDTH     = 64,
  parameter bit CLEAR_ON_SWAP = 1'b0
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  operand_pingpong_buffer_if.slave bus
);
  localparam int MAX_DIM = calc_max_dim(BUS_WIDTH, DATA_WIDTH);
  localparam int AW      = calc_addr_w(MAX_DIM);
  localparam int CW      = calc_cnt_w(MAX_DIM);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        len;
  logic                 rd_bank;
  logic                 swap_pending;
  logic                 done_q;
  logic                 clear_q;
  logic [BUS_WIDTH-1:0] rd_row0;
  logic [BUS_WIDTH-1:0] rd_row1;
  logic                 send;
  logic                 at_last;

  assign send    = (state == SEND);
  assign at_last = (cnt == len - CW'(1));

  // rd_bank only moves while IDLE or on the edge that leaves SEND.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      cnt          <= '0;
      len          <= '0;
      rd_bank      <= 1'b0;
      swap_pending <= 1'b0;
      done_q       <= 1'b0;
      clear_q      <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      clear_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_send_i) begin
            len <= (bus.dim_i > CW'(MAX_DIM)) ? CW'(MAX_DIM) : bus.dim_i;
            cnt <= '0;
            if (bus.dim_i == '0) done_q <= 1'b1;
            else                 state  <= SEND;
            if (bus.swap_i) swap_pending <= 1'b1;
          end else if (bus.swap_i || swap_pending) begin
            rd_bank      <= ~rd_bank;
            swap_pending <= 1'b0;
            clear_q      <= CLEAR_ON_SWAP;
          end
        end
        SEND: begin
          if (bus.swap_i) swap_pending <= 1'b1;
          if (bus.ready_i) begin
            cnt <= cnt + CW'(1);
            if (at_last) begin
              state  <= IDLE;
              done_q <= 1'b1;
              if (swap_pending || bus.swap_i) begin
                rd_bank      <= ~rd_bank;
                swap_pending <= 1'b0;
                clear_q      <= CLEAR_ON_SWAP;
              end
            end
          end
        end
      endcase
    end
  end

  // The write bank is always the one not being read.
  operand_pingpong_buffer_bank #(.DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH)) u_bank0 (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .we     (bus.write_enable_i && rd_bank),
    .waddr  (bus.address_i),
    .strobe (bus.strobe_i),
    .wdata  (bus.data_i),
    .clr    (clear_q && rd_bank),
    .raddr  (cnt[AW-1:0]),
    .rdata  (rd_row0)
  );

  operand_pingpong_buffer_bank #(.DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH)) u_bank1 (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .we     (bus.write_enable_i && !rd_bank),
    .waddr  (bus.address_i),
    .strobe (bus.strobe_i),
    .wdata  (bus.data_i),
    .clr    (clear_q && !rd_bank),
    .raddr  (cnt[AW-1:0]),
    .rdata  (rd_row1)
  );

  assign bus.valid_o   = send;
  assign bus.last_o    = send && at_last;
  assign bus.data_o    = send ? (rd_bank ? rd_row1 : rd_row0) : '0;
  assign bus.done_o    = done_q;
  assign bus.busy_o    = send || swap_pending;
  assign bus.rd_bank_o = rd_bank;

endmodule

// File: tb/tb_operand_pingpong_buffer.sv
// tb/tb_operand_pingpong_buffer.sv - scoreboard bench for the ping-pong operand buffer
module tb_operand_pingpong_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         sel = 1'b0;
  logic         we = 1'b0;
  logic [1:0]   addr = '0;
  logic [3:0]   strb = '0;
  logic [127:0] wdata = '0;
  logic         swap = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   dim = '0;
  logic         ready = 1'b1;

  logic [127:0] data;
  logic         valid, last, done, busy, rdb;

  operand_pingpong_buffer_if #(.DATA_WIDTH(32), .BUS_WIDTH(128)) bus_a ();
  operand_pingpong_buffer_if #(.DATA_WIDTH(32), .BUS_WIDTH(128)) bus_b ();

  operand_pingpong_buffer #(.DATA_WIDTH(32), .BUS_WIDTH(128), .CLEAR_ON_SWAP(1'b0)) u_dut_a (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus_a.slave));
  operand_pingpong_buffer #(.DATA_WIDTH(32), .BUS_WIDTH(128), .CLEAR_ON_SWAP(1'b1)) u_dut_b (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus_b.slave));

  assign bus_a.write_enable_i = !sel && we;
  assign bus_a.address_i      = addr;
  assign bus_a.strobe_i       = strb;
  assign bus_a.data_i         = wdata;
  assign bus_a.swap_i         = !sel && swap;
  assign bus_a.start_send_i   = !sel && start;
  assign bus_a.dim_i          = dim;
  assign bus_a.ready_i        = !sel && ready;
  assign bus_b.write_enable_i = sel && we;
  assign bus_b.address_i      = addr;
  assign bus_b.strobe_i       = strb;
  assign bus_b.data_i         = wdata;
  assign bus_b.swap_i         = sel && swap;
  assign bus_b.start_send_i   = sel && start;
  assign bus_b.dim_i          = dim;
  assign bus_b.ready_i        = sel && ready;

  assign data  = sel ? bus_b.data_o    : bus_a.data_o;
  assign valid = sel ? bus_b.valid_o   : bus_a.valid_o;
  assign last  = sel ? bus_b.last_o    : bus_a.last_o;
  assign done  = sel ? bus_b.done_o    : bus_a.done_o;
  assign busy  = sel ? bus_b.busy_o    : bus_a.busy_o;
  assign rdb   = sel ? bus_b.rd_bank_o : bus_a.rd_bank_o;

  always #5 clk = ~clk;

  logic [128:0] sb [$];
  logic [127:0] mdl [2][2][4];
  logic         exp_rd [2];
  int           n_cmp = 0;
  int           n_err = 0;

  function automatic logic [127:0] pat(input int seed, input int r);
    return {32'(seed + r*16 + 3), 32'(seed + r*16 + 2), 32'(seed + r*16 + 1), 32'(r + 1)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_rd[d] = 1'b0;
      for (int k = 0; k < 2; k++)
        for (int r = 0; r < 4; r++) mdl[d][k][r] = '0;
    end
    sb.delete();
  endtask

  task automatic write_row(input int a, input logic [127:0] d, input logic [3:0] s);
    we = 1'b1; addr = 2'(a); wdata = d; strb = s;
    for (int b = 0; b < 4; b++)
      if (s[b]) mdl[sel][!exp_rd[sel]][a][b*32 +: 32] = d[b*32 +: 32];
    tick();
    we = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
    exp_rd[sel] = !exp_rd[sel];
    if (sel) for (int r = 0; r < 4; r++) mdl[1][!exp_rd[1]][r] = '0;
    n_cmp++;
    if (rdb !== exp_rd[sel]) begin
      n_err++;
      $display("FAIL swap_rd_bank: got %0b expected %0b", rdb, exp_rd[sel]);
    end
  endtask

  task automatic run_stream(input int d, input int stall_beat, input int stall_len,
                            input int swap_beat, input int restart_beat);
    int n, beat, stalled, vcyc, exp_v;
    logic saw_done;
    n = (d > 4) ? 4 : d;
    for (int i = 0; i < n; i++) sb.push_back({(i == n - 1), mdl[sel][exp_rd[sel]][i]});
    exp_v = n + ((stall_beat >= 0 && stall_beat < n) ? stall_len : 0);
    start = 1'b1; dim = 3'(d); ready = 1'b1;
    tick();
    start = 1'b0;
    beat = 0; stalled = 0; vcyc = 0; saw_done = 1'b0;
    for (int guard = 0; guard < 60 && !saw_done; guard++) begin
      if (done === 1'b1) begin
        saw_done = 1'b1;
      end else begin
        swap = 1'b0; start = 1'b0;
        if (valid === 1'b1) begin
          vcyc++;
          n_cmp++;
          if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_in_send: got %0b expected 1", busy);
          end
          if (beat == stall_beat && stalled < stall_len) begin
            ready = 1'b0;
            stalled++;
          end else begin
            ready = 1'b1;
            if (beat == swap_beat) swap = 1'b1;
            if (beat == restart_beat) begin start = 1'b1; dim = 3'd1; end
            beat++;
          end
        end
        tick();
      end
    end
    swap = 1'b0; start = 1'b0; ready = 1'b1;
    n_cmp++;
    if (!saw_done) begin
      n_err++;
      $display("FAIL stream_timeout: got no done_o expected done_o within 60 cycles");
      sb.delete();
    end
    if (swap_beat >= 0) begin
      exp_rd[sel] = !exp_rd[sel];
      if (sel) for (int r = 0; r < 4; r++) mdl[1][!exp_rd[1]][r] = '0;
    end
    n_cmp++;
    if (rdb !== exp_rd[sel]) begin
      n_err++;
      $display("FAIL done_rd_bank: got %0b expected %0b", rdb, exp_rd[sel]);
    end
    n_cmp++;
    if (vcyc !== exp_v) begin
      n_err++;
      $display("FAIL valid_cycles: got %0d expected %0d", vcyc, exp_v);
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL beats_missing: got %0d left expected 0", sb.size());
      sb.delete();
    end
    tick();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL after_done: got done/busy %b expected 00", {done, busy});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus_a.valid_o, bus_a.last_o, bus_a.done_o, bus_a.busy_o, bus_a.rd_bank_o} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags_a: got %b expected 00000",
               {bus_a.valid_o, bus_a.last_o, bus_a.done_o, bus_a.busy_o, bus_a.rd_bank_o});
    end
    n_cmp++;
    if ({bus_b.valid_o, bus_b.last_o, bus_b.done_o, bus_b.busy_o, bus_b.rd_bank_o} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags_b: got %b expected 00000",
               {bus_b.valid_o, bus_b.last_o, bus_b.done_o, bus_b.busy_o, bus_b.rd_bank_o});
    end
    n_cmp++;
    if ((bus_a.data_o | bus_b.data_o) !== 128'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h expected 0", bus_a.data_o | bus_b.data_o);
    end
    model_reset();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    for (int r = 0; r < 4; r++) write_row(r, pat(32'h100, r), 4'hF);
    do_swap();
    run_stream(4, -1, 0, -1, -1);
  endtask

  task automatic test_strobe_merge();
    for (int r = 0; r < 4; r++) write_row(r, pat(32'h200, r), 4'hF);
    write_row(2, {4{32'hAAAA_AAAA}}, 4'hF);
    write_row(2, {4{32'h5555_5555}}, 4'b0101);
    n_cmp++;
    if (mdl[0][0][2] !== {32'hAAAA_AAAA, 32'h5555_5555, 32'hAAAA_AAAA, 32'h5555_5555}) begin
      n_err++;
      $display("FAIL strobe_model: got %h expected alternating 5555/AAAA", mdl[0][0][2]);
    end
    do_swap();
    run_stream(4, -1, 0, -1, -1);
  endtask

  task automatic test_backpressure();
    run_stream(4, 1, 3, -1, -1);
  endtask

  task automatic test_swap_during_send();
    for (int r = 0; r < 4; r++) write_row(r, pat(32'h300, r), 4'hF);
    run_stream(4, -1, 0, 0, -1);
    run_stream(4, -1, 0, -1, -1);
  endtask

  task automatic test_edges();
    run_stream(0, -1, 0, -1, -1);
    run_stream(7, -1, 0, -1, -1);
    run_stream(4, -1, 0, -1, 1);
    run_stream(2, 0, 1, -1, -1);
  endtask

  task automatic test_reset_and_clear();
    start = 1'b1; dim = 3'd4; ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if (valid !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_valid: got %0b expected 1", valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({valid, busy, rdb, data} !== 131'h0) begin
      n_err++;
      $display("FAIL async_reset: got valid/busy/rd %b data %h expected zeros", {valid, busy, rdb}, data);
    end
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    model_reset();
    tick();
    run_stream(4, -1, 0, -1, -1);
    do_swap();
    run_stream(4, -1, 0, -1, -1);

    sel = 1'b1;
    tick();
    for (int r = 0; r < 4; r++) write_row(r, pat(32'h500, r), 4'hF);
    do_swap();
    for (int r = 0; r < 4; r++) write_row(r, pat(32'h600, r), 4'hF);
    do_swap();
    write_row(1, {4{32'hC0DE_0001}}, 4'b0010);
    n_cmp++;
    if (mdl[1][1][1] !== {64'h0, 32'hC0DE_0001, 32'h0}) begin
      n_err++;
      $display("FAIL clear_model: got %h expected only element 1 set", mdl[1][1][1]);
    end
    run_stream(4, -1, 0, -1, -1);
    do_swap();
    run_stream(4, -1, 0, -1, -1);
    sel = 1'b0;
    tick();
  endtask

  initial begin : monitor
    logic pv, pr, pl;
    logic [127:0] pd;
    logic [128:0] e;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          n_cmp++;
          if (valid !== 1'b1 || data !== pd || last !== pl) begin
            n_err++;
            $display("FAIL hold_stable: got v%0b l%0b %h expected v1 l%0b %h", valid, last, data, pl, pd);
          end
        end
        if (valid === 1'b1 && ready === 1'b1) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL extra_beat: got %h expected no beat", data);
          end else begin
            e = sb.pop_front();
            if ({last, data} !== e) begin
              n_err++;
              $display("FAIL beat: got l%0b %h expected l%0b %h", last, data, e[128], e[127:0]);
            end
          end
        end
        if (valid !== 1'b1) begin
          n_cmp++;
          if ({last, data} !== 129'h0) begin
            n_err++;
            $display("FAIL idle_output: got l%0b %h expected 0", last, data);
          end
        end
        pv = valid; pr = ready; pd = data; pl = last;
      end
    end
  end

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_strobe_merge();
    test_backpressure();
    test_swap_during_send();
    test_edges();
    test_reset_and_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
